// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter family.
package counter_pkg;

  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;
  localparam logic CNT_DIR_DN    = 1'b0;
  localparam logic CNT_DIR_UP    = 1'b1;

endpackage

// File: rtl/cnt_next_val.sv
// Combinational step function: next count and terminal event for one enabled cycle.
module cnt_next_val
  import counter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] count,
  input  logic [N-1:0] max_val,
  input  logic         up_dn,
  input  logic         mode,
  output logic [N-1:0] next_count,
  output logic         term_event
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] count_inc;
  logic [N-1:0] count_dec;

  assign count_inc = count + ONE;
  assign count_dec = count - ONE;

  // Terminal detection is checked before any arithmetic, so N-bit roll-over never occurs.
  always_comb begin
    next_count = count;
    term_event = 1'b0;
    if (up_dn == CNT_DIR_UP) begin
      if (count >= max_val) begin
        if (mode == CNT_MODE_WRAP) begin
          next_count = '0;
          term_event = 1'b1;
        end else begin
          next_count = max_val;
        end
      end else begin
        next_count = count_inc;
        term_event = (mode == CNT_MODE_SAT) && (count_inc == max_val);
      end
    end else begin
      if (count == '0) begin
        if (mode == CNT_MODE_WRAP) begin
          next_count = max_val;
          term_event = 1'b1;
        end
      end else begin
        next_count = count_dec;
        term_event = (mode == CNT_MODE_SAT) && (count == ONE);
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap/saturate modes and a terminal-event pulse.
// Define COUNTER_WRAP_CNT_EN to add the saturating wrap_cnt event counter output.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int N      = 3,
  parameter int WRAP_W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         up_dn,
  input  logic         mode,
  input  logic [N-1:0] max_val,
  output logic [N-1:0] count_out,
  output logic         done,
  output logic         at_max,
  output logic         at_zero
`ifdef COUNTER_WRAP_CNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  logic [N-1:0] count_reg;
  logic [N-1:0] count_next;
  logic         done_reg;
  logic         done_next;
  logic [N-1:0] step_val;
  logic         step_term;
  logic [N-1:0] load_clamped;

  cnt_next_val #(.N(N)) u_step (
    .count      (count_reg),
    .max_val    (max_val),
    .up_dn      (up_dn),
    .mode       (mode),
    .next_count (step_val),
    .term_event (step_term)
  );

  assign load_clamped = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    count_next = count_reg;
    done_next  = 1'b0;
    if (load) begin
      count_next = load_clamped;
    end else if (en) begin
      count_next = step_val;
      done_next  = step_term;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  assign count_out = count_reg;
  assign done      = done_reg;
  assign at_max    = (count_reg >= max_val);
  assign at_zero   = (count_reg == '0);

`ifdef COUNTER_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_cnt_reg;
  logic [WRAP_W-1:0] wrap_cnt_next;

  always_comb begin
    wrap_cnt_next = wrap_cnt_reg;
    if (load) begin
      wrap_cnt_next = '0;
    end else if (done_next && (wrap_cnt_reg != '1)) begin
      wrap_cnt_next = wrap_cnt_reg + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrap_cnt_reg <= '0;
    end else begin
      wrap_cnt_reg <= wrap_cnt_next;
    end
  end

  assign wrap_cnt = wrap_cnt_reg;
`else
  logic unused_wrap_w;
  assign unused_wrap_w = ^WRAP_W;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized self-checking bench for updown_mod_counter against a spec-level model.
module tb_updown_mod_counter;

  localparam int N      = 3;
  localparam int WRAP_W = 2;
  localparam int MAXW   = (1 << WRAP_W) - 1;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         load;
  logic [N-1:0] load_val;
  logic         up_dn;
  logic         mode;
  logic [N-1:0] max_val;
  logic [N-1:0] count_out;
  logic         done;
  logic         at_max;
  logic         at_zero;
`ifdef COUNTER_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_cnt;
`endif

  updown_mod_counter #(.N(N), .WRAP_W(WRAP_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .up_dn     (up_dn),
    .mode      (mode),
    .max_val   (max_val),
    .count_out (count_out),
    .done      (done),
    .at_max    (at_max),
    .at_zero   (at_zero)
`ifdef COUNTER_WRAP_CNT_EN
    ,
    .wrap_cnt  (wrap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state as plain integers.
  int m_cnt  = 0;
  int m_done = 0;
  int m_wc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_done = 0;
    m_wc   = 0;
  endtask

  // Applies the counting rules to the integer model using the inputs present at the edge.
  task automatic model_edge();
    int mx;
    mx = int'(max_val);
    if (load) begin
      m_cnt  = (int'(load_val) < mx) ? int'(load_val) : mx;
      m_done = 0;
      m_wc   = 0;
    end else if (!en) begin
      m_done = 0;
    end else if (up_dn) begin
      if (m_cnt >= mx) begin
        m_done = (mode == 1'b0) ? 1 : 0;
        m_cnt  = (mode == 1'b0) ? 0 : mx;
      end else begin
        m_cnt  = m_cnt + 1;
        m_done = (mode == 1'b1 && m_cnt == mx) ? 1 : 0;
      end
    end else begin
      if (m_cnt == 0) begin
        m_done = (mode == 1'b0) ? 1 : 0;
        m_cnt  = (mode == 1'b0) ? mx : 0;
      end else begin
        m_done = (mode == 1'b1 && m_cnt == 1) ? 1 : 0;
        m_cnt  = m_cnt - 1;
      end
    end
    if (!load && m_done == 1 && m_wc < MAXW) m_wc = m_wc + 1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/count"}, 32'(count_out), m_cnt);
    chk({tag, "/done"}, 32'(done), m_done);
    chk({tag, "/at_max"}, 32'(at_max), (m_cnt >= int'(max_val)) ? 1 : 0);
    chk({tag, "/at_zero"}, 32'(at_zero), (m_cnt == 0) ? 1 : 0);
`ifdef COUNTER_WRAP_CNT_EN
    chk({tag, "/wrap_cnt"}, 32'(wrap_cnt), m_wc);
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    $display("%s: ld=%0d en=%0d up=%0d sat=%0d max=%0d -> count=%0d done=%0d",
             tag, load, en, up_dn, mode, max_val, count_out, done);
  endtask

  task automatic set_in(input logic l, input logic e, input logic u, input logic m,
                        input int mx, input int lv);
    load     = l;
    en       = e;
    up_dn    = u;
    mode     = m;
    max_val  = N'(mx);
    load_val = N'(lv);
  endtask

  initial begin
    rstn = 1'b0;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 7, 0);
    #3;
    model_reset();
    check_outputs("reset");
    #9 rstn = 1'b1;

    // Free-running style wrap at max_val = 7.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 7, 0);
    for (int k = 1; k <= 10; k++) begin
      step("wrap7");
      chk("wrap7_seq", 32'(count_out), k % 8);
      chk("wrap7_done", 32'(done), (k == 8) ? 1 : 0);
    end
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_count", 32'(count_out), 0);
    chk("async_rst_done", 32'(done), 0);
    #2 rstn = 1'b1;

    // Modulo 5 wrap, then down-wrap from 0.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 5, 0);
    for (int k = 1; k <= 6; k++) step("mod5_up");
    chk("mod5_wrap_zero", 32'(count_out), 0);
    chk("mod5_wrap_done", 32'(done), 1);
    up_dn = 1'b0;
    step("mod5_dn");
    chk("dn_wrap_val", 32'(count_out), 5);
    chk("dn_wrap_done", 32'(done), 1);
    step("mod5_dn");
    step("mod5_dn");
    chk("dn_seq", 32'(count_out), 3);

    // Saturate up from 3 and down from 1.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 5, 3);
    step("sat_load");
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 5, 0);
    step("sat_up");
    step("sat_up");
    chk("sat_reach", 32'(count_out), 5);
    chk("sat_reach_done", 32'(done), 1);
    for (int k = 0; k < 3; k++) begin
      step("sat_hold");
      chk("sat_hold_done", 32'(done), 0);
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 5, 1);
    step("sat_load");
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 5, 0);
    step("sat_dn");
    chk("sat_dn_done", 32'(done), 1);
    step("sat_dn");
    chk("sat_dn_hold", 32'(count_out), 0);

    // Load beats enable and clamps to max_val.
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 5, 6);
    step("load_clamp");
    chk("load_clamp_val", 32'(count_out), 5);
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 5, 2);
    step("load_two");
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 5, 0);
    step("resume");
    chk("resume_val", 32'(count_out), 3);

    // max_val lowered below the count.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 7, 6);
    step("dyn_load");
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 3, 0);
    step("dyn_wrap");
    chk("dyn_wrap_done", 32'(done), 1);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 7, 6);
    step("dyn_load");
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 3, 0);
    step("dyn_sat");
    chk("dyn_sat_val", 32'(count_out), 3);
    en = 1'b0;
    step("hold");
    step("hold");

    // max_val = 0 in wrap mode: done every enabled cycle, wrap_cnt saturates.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    step("zero_load");
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step("zero_wrap");
      chk("zero_wrap_done", 32'(done), 1);
`ifdef COUNTER_WRAP_CNT_EN
      chk("wrap_cnt_seq", 32'(wrap_cnt), (k < 3) ? k : 3);
`endif
    end
    load = 1'b1;
    step("wc_clear");
`ifdef COUNTER_WRAP_CNT_EN
    chk("wrap_cnt_clear", 32'(wrap_cnt), 0);
`endif

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom_range(0, 1));
      mode     = 1'($urandom_range(0, 1));
      load_val = N'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) max_val = N'($urandom_range(0, 7));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised successor to the free-running N-bit up counter. Adds up/down direction, a runtime-programmable terminal value (modulo), wrap or saturate mode, count enable, synchronous load, and a one-cycle done pulse on each terminal event. Intended as the general-purpose timer/counter primitive for the sequential-logic blocks (baud dividers, timeouts, event counters).

Parameters:
N, 3, counter width in bits (N >= 2)
WRAP_W, 4, width of wrap_cnt (used only when COUNTER_WRAP_CNT_EN is defined)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
en  input  1  count enable; one step per cycle while high
load  input  1  synchronous load strobe; overrides en
load_val  input  N  value loaded on load
up_dn  input  1  1 = count up, 0 = count down
mode  input  1  0 = wrap, 1 = saturate
max_val  input  N  terminal value for up count and reload value for down wrap
count_out  output  N  registered count
done  output  1  registered one-cycle terminal-event pulse
at_max  output  1  combinational: count_out >= max_val
at_zero  output  1  combinational: count_out == 0

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low (rstn). All state is clocked on the rising edge of clk.
- Reset: count_out = 0 and done = 0. If COUNTER_WRAP_CNT_EN is defined, wrap_cnt = 0 as well. Reset takes effect immediately, including in the middle of a count.
- Priority per cycle: load > en > hold.
- load:
  - count_out <= min(load_val, max_val), so an out-of-range load is clamped.
  - done <= 0.
  - up_dn, mode and en are ignored in that cycle.
- en = 0 with no load: count_out holds and done <= 0.
- Up count (en = 1, up_dn = 1):
  - count_out < max_val: count_out <= count_out + 1 and done <= 0.
  - count_out >= max_val, wrap mode: count_out <= 0 and done <= 1.
  - count_out >= max_val, saturate mode: count_out <= max_val and done <= 0.
  - Saturate mode only: done <= 1 on the step where count_out + 1 == max_val. done therefore rises in the same cycle count_out first shows max_val and is not repeated while the count holds.
- Down count (en = 1, up_dn = 0):
  - count_out > 0: count_out <= count_out - 1 and done <= 0.
  - count_out == 0, wrap mode: count_out <= max_val and done <= 1.
  - count_out == 0, saturate mode: hold 0 and done <= 0.
  - Saturate mode only: done <= 1 on the step where count_out == 1, i.e. the step that reaches 0.
- Arithmetic is N-bit unsigned. There is no natural roll-over: terminal detection always precedes the increment or decrement.
- max_val = {N{1'b1}}, up, wrap mode: behaves exactly like the plain N-bit up counter (done pulses each 2^N cycles).
- max_val = 0:
  - Up, wrap mode: count stays 0 and done = 1 on every enabled cycle.
  - Down, wrap mode: same as up, wrap.
  - Saturate mode: holds 0 with no done.
- max_val lowered below count_out mid-count:
  - Up, wrap mode: the next enabled step is a terminal event (count goes to 0, done = 1).
  - Up, saturate mode: clamps to max_val on the next enabled step, with no done pulse.
- up_dn or mode changed mid-count: takes effect on the next step. There is no pipeline and latency is 1 cycle from input to count_out.

Optional Feature:
COUNTER_WRAP_CNT_EN
- Defined: adds output wrap_cnt [WRAP_W-1:0].
  - Increments on every cycle in which done is set to 1.
  - Saturates at all ones.
  - Cleared by load and by reset.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package counter_pkg:
  - CNT_MODE_WRAP = 1'b0, CNT_MODE_SAT = 1'b1
  - CNT_DIR_DN = 1'b0, CNT_DIR_UP = 1'b1
- One combinational sub-module, cnt_next_val. It takes count, max_val, up_dn and mode, and returns next_count and term_event. The top level holds the registers, load/enable priority and the optional wrap_cnt.

Test Plan:
1. Reset and basic wrap: N=3, max_val=7, up, wrap, en=1 for 10 cycles -> count 0..7,0,1; done=1 only in the cycle count_out=0 after 7; assert rstn=0 mid-count -> count_out=0 and done=0 immediately.
2. Modulo wrap: max_val=5, up, wrap -> sequence 0,1,2,3,4,5,0; done high with the 0; switch to down -> 0 wraps to 5 with done=1, then 4,3.
3. Saturate: max_val=5, up, sat from 3 -> 4, 5 (done=1 with 5), then 5 held with done=0 for 3 cycles; down, sat from 1 -> 0 with done=1, then holds 0.
4. Load priority and clamp: load=1 and en=1 with load_val=6 while max_val=5 -> count_out=5, done=0; load_val=2 -> 2 and counting resumes from 2.
5. Dynamic max_val: count=6, max_val changed 7->3, up, wrap -> next count 0 with done=1; same case in sat mode -> count 3, done=0; en=0 cycles -> count holds, done=0.
6. COUNTER_WRAP_CNT_EN, WRAP_W=2: 5 wrap events -> wrap_cnt=1,2,3,3,3; load -> wrap_cnt=0.
